// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and lookahead functions for the pipelined CLA adder
package cla_pkg;

  localparam int GROUP_W = 4;
  // Widest stage the second-level lookahead function handles (groups per stage).
  localparam int MAX_GPS = 16;

  // Group propagate/generate of one 4-bit group. Kept apart from the sum path so
  // that pg/gg never depend on the group carry-in, which is formed from them.
  function automatic logic [1:0] cla_group_pg_gg(input logic [GROUP_W-1:0] a,
                                                 input logic [GROUP_W-1:0] bp);
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic               pg;
    logic               gg;
    p  = a ^ bp;
    g  = a & bp;
    pg = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {pg, gg};
  endfunction

  // Internal 4-bit lookahead carries; returns {carry into bit 3, sum[3:0]}.
  function automatic logic [GROUP_W:0] cla_group_sum(input logic [GROUP_W-1:0] a,
                                                     input logic [GROUP_W-1:0] bp,
                                                     input logic               cin);
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] c;
    p    = a ^ bp;
    g    = a & bp;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return {c[3], p ^ c};
  endfunction

  // Second-level lookahead: carry into every group of a stage (bit n = carry out of
  // group n-1) as a flat sum of products over (pg, gg), never rippled group to group.
  function automatic logic [MAX_GPS:0] cla_lookahead(input logic [MAX_GPS-1:0] pg,
                                                     input logic [MAX_GPS-1:0] gg,
                                                     input logic               cin);
    logic [MAX_GPS:0] c;
    logic             term;
    for (int j = 0; j <= MAX_GPS; j++) begin
      term = cin;
      for (int m = 0; m < j; m++) term = term & pg[m];
      c[j] = term;
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int m = i + 1; m < j; m++) term = term & pg[m];
        c[j] = c[j] | term;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_group_unit.sv
// rtl/cla_group_unit.sv - one 4-bit carry-lookahead group
module cla_group_unit
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a_i,
  input  logic [GROUP_W-1:0] b_i,
  input  logic               c_i,
  output logic [GROUP_W-1:0] s_o,
  output logic               pg_o,
  output logic               gg_o,
  output logic               c3_o
);

  assign {pg_o, gg_o} = cla_group_pg_gg(a_i, b_i);
  assign {c3_o, s_o}  = cla_group_sum(a_i, b_i, c_i);

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GPS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP_W;
  localparam int L  = NG / GPS;
  localparam int SW = GPS * GROUP_W;

  // Stage record: a/b' still needed by later stages, sum bits resolved so far,
  // carry handed to the next stage and the carry into the MSB for the overflow flag.
  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             cm;
  } stage_rec_t;

  stage_rec_t st_q  [L];
  stage_rec_t st_in [L];
  stage_rec_t st_d  [L];
  logic [L-1:0] load;
  logic zero_q;
  logic ovf_q;

  // Subtraction is a + ~b + 1, so the operand inversion and forced carry happen here.
  assign st_in[0] = '{v: in_valid, a: a, b: (sub ? ~b : b), s: '0, c: (sub | cin), cm: 1'b0};

  for (genvar k = 1; k < L; k++) begin : g_link
    assign st_in[k] = st_q[k-1];
  end

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic [GPS-1:0]     pg;
    logic [GPS-1:0]     gg;
    logic [GPS-1:0]     c3;
    logic [SW-1:0]      s;
    logic [MAX_GPS-1:0] pg_x;
    logic [MAX_GPS-1:0] gg_x;
    logic [MAX_GPS:0]   cc;
    logic               unused_c;
    stage_rec_t         d;

    // Pad the stage's group terms out to the lookahead function's fixed width.
    always_comb begin
      pg_x = '0;
      gg_x = '0;
      pg_x[GPS-1:0] = pg;
      gg_x[GPS-1:0] = gg;
    end

    assign cc = cla_lookahead(pg_x, gg_x, st_in[k].c);

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      localparam int LO = (k * GPS + j) * GROUP_W;
      cla_group_unit u_grp (
        .a_i  (st_in[k].a[LO +: GROUP_W]),
        .b_i  (st_in[k].b[LO +: GROUP_W]),
        .c_i  (cc[j]),
        .s_o  (s[j*GROUP_W +: GROUP_W]),
        .pg_o (pg[j]),
        .gg_o (gg[j]),
        .c3_o (c3[j])
      );
    end

    // Only the top group's MSB carry and the stage carry-out are consumed.
    assign unused_c = ^{c3, cc};

    // Next stage record: drop in this stage's sum bits and carry-out.
    always_comb begin
      d = st_in[k];
      d.s[k*SW +: SW] = s;
      d.c = cc[GPS];
      if (k == L - 1) d.cm = c3[GPS-1];
    end

    assign st_d[k] = d;
  end

  // A stage loads when empty or when its successor (or the consumer) takes its beat.
  always_comb begin
    load = '0;
    load[L-1] = !st_q[L-1].v | out_ready;
    for (int k = L - 2; k >= 0; k--) load[k] = !st_q[k].v | load[k+1];
  end

  assign in_ready = load[0];

  // Stage registers and output flags; stages that do not load hold their contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < L; k++) st_q[k] <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      for (int k = 0; k < L; k++) begin
        if (load[k]) st_q[k] <= st_d[k];
      end
      if (load[L-1]) begin
        zero_q <= (st_d[L-1].s == '0);
        ovf_q  <= st_d[L-1].cm ^ st_d[L-1].c;
      end
    end
  end

  assign out_valid = st_q[L-1].v;
  assign sum       = st_q[L-1].s;
  assign cout      = st_q[L-1].c;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - scoreboard bench for pipelined_cla_adder over three configurations
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int W   = (gi == 1) ? 4 : (gi == 2) ? 64 : 32;
    localparam int G   = (gi == 1) ? 1 : (gi == 2) ? 4 : 2;
    localparam int LAT = W / 4 / G;

    typedef struct packed {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      logic         z;
      logic         lat;
      logic [31:0]  t;
    } exp_t;

    logic rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [W-1:0] a, b, sum;
    logic rdy_rand;
    exp_t q[$];

    pipelined_cla_adder #(.WIDTH(W), .GPS(G)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mc, input logic ms, input logic ml);
      logic [W-1:0] bb;
      logic [W:0]   r;
      exp_t         e;
      bb   = ms ? ~mb : mb;
      r    = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
      e.s  = r[W-1:0];
      e.co = r[W];
      e.ov = (ma[W-1] == bb[W-1]) && (r[W-1] != ma[W-1]);
      e.z  = (r[W-1:0] == '0);
      e.lat = ml;
      e.t  = 32'd0;
      return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov, input logic z);
      exp_t e;
      e.s = s; e.co = co; e.ov = ov; e.z = z; e.lat = 1'b1; e.t = 32'd0;
      return e;
    endfunction

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic ts, input exp_t e);
      int n;
      n = 0;
      @(negedge clk);
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      #1;
      while (!in_ready && n < 1000) begin
        check($sformatf("c%0d_stall_cause", gi), {(q.size() == LAT), out_ready}, 2'b10);
        @(negedge clk);
        #1;
        n++;
      end
      if (!in_ready) check($sformatf("c%0d_accept_timeout", gi), 1'b0, 1'b1);
      else begin
        e.t = cyc;
        q.push_back(e);
      end
    endtask

    task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b0;
      while (q.size() != 0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("c%0d_drain", gi), (q.size() == 0), 1'b1);
      repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic init_reset();
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1; rdy_rand = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check($sformatf("c%0d_reset_state", gi), {out_valid, sum, cout, ovf, zero, in_ready},
            {1'b0, {W{1'b0}}, 4'b0001});
      rst = 1'b0;
    endtask

    task automatic corners();
      logic [W-1:0] v [4];
      v[0] = '0;
      v[1] = '1;
      v[2] = '0;
      v[2][W-1] = 1'b1;
      v[3] = W'(1);
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          for (int s = 0; s < 2; s++)
            send(v[i], v[j], 1'(i + j), 1'(s), model(v[i], v[j], 1'(i + j), 1'(s), 1'b1));
      drain();
    endtask

    task automatic stream(input int nb);
      logic [63:0] ra, rb;
      logic rc, rs;
      rdy_rand = 1'b1;
      for (int i = 0; i < nb; i++) begin
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        send(ra[W-1:0], rb[W-1:0], rc, rs, model(ra[W-1:0], rb[W-1:0], rc, rs, 1'b0));
      end
      drain();
      rdy_rand = 1'b0;
      out_ready = 1'b1;
    endtask

    initial begin
      forever begin
        @(negedge clk);
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        #4;
        if (!rst && out_valid && out_ready) begin
          exp_t e;
          if (q.size() == 0) check($sformatf("c%0d_unexpected_output", gi), 1'b1, 1'b0);
          else begin
            e = q.pop_front();
            check($sformatf("c%0d_result", gi), {sum, cout, ovf, zero}, {e.s, e.co, e.ov, e.z});
            if (e.lat) check($sformatf("c%0d_latency", gi), cyc - e.t, LAT);
          end
        end
      end
    end

    if (gi == 0) begin : g_main
      initial begin
        init_reset();
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, mk(32'h0000_0003, 1'b0, 1'b0, 1'b0));
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b1, 1'b1));
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
        send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
        drain();
        corners();
        stream(100);
        // Reset with three beats in flight, the oldest already at the output.
        out_ready = 1'b0;
        send(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, mk(32'h0000_3333, 1'b0, 1'b0, 1'b0));
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, mk(32'h0000_0030, 1'b0, 1'b0, 1'b0));
        send(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, mk(32'h0000_0300, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("c0_inflight_valid", out_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("c0_midreset_state", {out_valid, sum, cout, ovf, zero, in_ready},
              {1'b0, 32'h0, 4'b0001});
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, mk(32'h2345_6789, 1'b0, 1'b0, 1'b0));
        drain();
        n_done++;
      end
    end else begin : g_sweep
      initial begin
        init_reset();
        corners();
        stream(60);
        n_done++;
      end
    end
  end

  initial begin
    int n;
    n = 0;
    while (n_done < 3 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (n_done < 3) check("global_timeout", n_done, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
